// File: rtl/pci_bus_arbiter.sv
// Central PCI bus arbiter: round-robin REQ_/GNT_ arbitration with hidden
// arbitration, bus parking and a grant-to-FRAME_ timeout.
module pci_bus_arbiter #(
    parameter int unsigned NUM_MASTERS = 4,
    parameter int unsigned PARK_MASTER = 0,
    parameter int unsigned GNT_TIMEOUT = 16
) (
    input  logic                           clk,
    input  logic                           reset_,
    input  logic [NUM_MASTERS-1:0]         REQ_,
    input  logic                           FRAME_,
    input  logic                           IRDY_,
    output logic [NUM_MASTERS-1:0]         GNT_,
    output logic [$clog2(NUM_MASTERS)-1:0] owner,
    output logic                           owner_vld,
    output logic                           bus_idle,
    output logic                           timeout_err
);

    localparam int unsigned OW = $clog2(NUM_MASTERS);
    localparam int unsigned CW = $clog2(GNT_TIMEOUT + 1);
    localparam logic [OW-1:0] PARK_IDX  = OW'(PARK_MASTER);
    localparam logic [OW-1:0] LAST_INIT = OW'(NUM_MASTERS - 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(GNT_TIMEOUT - 1);
    localparam logic [NUM_MASTERS-1:0] ONE      = NUM_MASTERS'(1);
    localparam logic [NUM_MASTERS-1:0] PARK_GNT = ~(ONE << PARK_MASTER);

    typedef enum logic [2:0] {IDLE, PARK, GRANT, BUSY, GAP} state_t;

    state_t                 state_q;
    logic [NUM_MASTERS-1:0] gnt_q;
    logic [OW-1:0]          owner_q;
    logic [OW-1:0]          last_q;
    logic                   vld_q;
    logic                   idle_q;
    logic                   terr_q;
    logic [CW-1:0]          cnt_q;

    logic                   start;
    logic                   any_req;
    logic                   other_req;
    logic                   own_rel;
    logic [OW-1:0]          winner;
    logic [NUM_MASTERS-1:0] own_mask;
    logic [NUM_MASTERS-1:0] win_gnt;

    // Rotating priority: first requester after the previous owner wins.
    always_comb begin
        logic          found;
        logic [OW-1:0] idx;
        winner = last_q;
        found  = 1'b0;
        idx    = '0;
        for (int unsigned i = 1; i <= NUM_MASTERS; i++) begin
            idx = OW'((32'(last_q) + i) % NUM_MASTERS);
            if (!found && !REQ_[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        own_mask  = ONE << owner_q;
        win_gnt   = ~(ONE << winner);
        any_req   = ~&REQ_;
        other_req = |(~REQ_ & ~own_mask);
        own_rel   = REQ_[owner_q];
        start     = ~FRAME_ & idle_q;
    end

    always_ff @(posedge clk) begin
        if (!reset_) begin
            state_q <= IDLE;
            gnt_q   <= '1;
            owner_q <= '0;
            last_q  <= LAST_INIT;
            vld_q   <= 1'b0;
            idle_q  <= 1'b1;
            terr_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            idle_q <= FRAME_ & IRDY_;
            terr_q <= 1'b0;
            unique case (state_q)
                IDLE, GAP: begin
                    vld_q <= 1'b1;
                    if (any_req) begin
                        state_q <= GRANT;
                        gnt_q   <= win_gnt;
                        owner_q <= winner;
                        cnt_q   <= '0;
                    end else begin
                        state_q <= PARK;
                        gnt_q   <= PARK_GNT;
                        owner_q <= PARK_IDX;
                    end
                end
                PARK: begin
                    if (start) begin
                        state_q <= BUSY;
                    end else if (any_req) begin
                        // The parked master keeps its grant when it wins outright.
                        if (winner == PARK_IDX) begin
                            state_q <= GRANT;
                            cnt_q   <= '0;
                        end else begin
                            state_q <= GAP;
                            gnt_q   <= '1;
                            vld_q   <= 1'b0;
                        end
                    end
                end
                GRANT: begin
                    if (start) begin
                        state_q <= BUSY;
                    end else if (own_rel || (idle_q && cnt_q == CNT_LAST)) begin
                        state_q <= GAP;
                        gnt_q   <= '1;
                        vld_q   <= 1'b0;
                        last_q  <= owner_q;
                        terr_q  <= ~own_rel;
                    end else if (idle_q) begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                BUSY: begin
                    if (other_req || (idle_q && own_rel)) begin
                        state_q <= other_req ? GAP : IDLE;
                        gnt_q   <= '1;
                        vld_q   <= 1'b0;
                        last_q  <= owner_q;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    gnt_q   <= '1;
                    vld_q   <= 1'b0;
                end
            endcase
        end
    end

    assign GNT_        = gnt_q;
    assign owner       = owner_q;
    assign owner_vld   = vld_q;
    assign bus_idle    = idle_q;
    assign timeout_err = terr_q;

endmodule

// File: tb/tb_pci_bus_arbiter.sv
// Self-checking bench for pci_bus_arbiter: vector table, directed corner
// sequences and randomized traffic against a grant-holder reference model.
module tb_pci_bus_arbiter;

    localparam int N  = 4;
    localparam int TO = 16;
    localparam int PM = 0;

    logic       clk = 1'b0;
    logic       reset_;
    logic       FRAME_;
    logic       IRDY_;
    logic [3:0] REQ_;
    logic [3:0] GNT_;
    logic [1:0] owner;
    logic       owner_vld;
    logic       bus_idle;
    logic       timeout_err;

    int n_checks = 0;
    int n_pass   = 0;
    bit armed    = 1'b0;

    // Reference model: who holds the grant (-1 = nobody) plus mode flags.
    int m_hold, m_last, m_cnt;
    bit m_busy, m_park, m_idle, m_terr;

    always #5 clk = ~clk;

    pci_bus_arbiter #(
        .NUM_MASTERS(N),
        .PARK_MASTER(PM),
        .GNT_TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .reset_(reset_),
        .REQ_(REQ_),
        .FRAME_(FRAME_),
        .IRDY_(IRDY_),
        .GNT_(GNT_),
        .owner(owner),
        .owner_vld(owner_vld),
        .bus_idle(bus_idle),
        .timeout_err(timeout_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (armed) begin
            n_checks++;
            if ($onehot0(~GNT_)) n_pass++;
            else $display("FAIL onehot_gnt: GNT_=%b expected at most one low bit", GNT_);
        end
    end

    function automatic int winner_of(input logic [3:0] req, input int last);
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (last + k) % N;
            if (!req[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [3:0] gnt_of(input int h);
        logic [3:0] one;
        one = 4'b0001;
        if (h < 0) return 4'hF;
        return ~(one << h);
    endfunction

    task automatic model_step(input logic rst, input logic [3:0] req, input logic fr, input logic ir);
        bit start, others, terr;
        int w;
        if (!rst) begin
            m_hold = -1; m_last = N - 1; m_cnt = 0;
            m_busy = 0; m_park = 0; m_idle = 1; m_terr = 0;
            return;
        end
        start  = !fr && m_idle;
        w      = winner_of(req, m_last);
        terr   = 0;
        others = 0;
        for (int k = 0; k < N; k++)
            if (k != m_hold && !req[k]) others = 1;
        if (m_hold < 0) begin
            if (w >= 0) begin m_hold = w; m_cnt = 0; end
            else begin m_hold = PM; m_park = 1; end
        end else if (m_park) begin
            if (start) begin m_busy = 1; m_park = 0; end
            else if (w == PM) begin m_park = 0; m_cnt = 0; end
            else if (w >= 0) begin m_park = 0; m_hold = -1; end
        end else if (m_busy) begin
            if (others || (m_idle && req[m_hold])) begin
                m_last = m_hold; m_hold = -1; m_busy = 0;
            end
        end else begin
            if (start) m_busy = 1;
            else if (req[m_hold]) begin m_last = m_hold; m_hold = -1; end
            else if (m_idle && m_cnt == TO - 1) begin terr = 1; m_last = m_hold; m_hold = -1; end
            else if (m_idle) m_cnt++;
        end
        m_idle = fr & ir;
        m_terr = terr;
    endtask

    task automatic step(input logic rst, input logic [3:0] req, input logic fr, input logic ir);
        logic [8:0] act, exp;
        reset_ = rst; REQ_ = req; FRAME_ = fr; IRDY_ = ir;
        @(posedge clk);
        model_step(rst, req, fr, ir);
        #1;
        armed = 1'b1;
        exp = {gnt_of(m_hold), m_hold >= 0, (m_hold >= 0) ? 2'(m_hold) : 2'd0, m_idle, m_terr};
        act = {GNT_, owner_vld, (m_hold >= 0) ? owner : 2'd0, bus_idle, timeout_err};
        check("model", 32'(act), 32'(exp));
    endtask

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic       fr;
        logic       ir;
        logic [3:0] gnt;
        logic       vld;
        logic [1:0] own;
        logic       idle;
        logic       terr;
    } vec_t;

    vec_t tbl[13];

    initial begin
        reset_ = 1'b0; REQ_ = 4'hF; FRAME_ = 1'b1; IRDY_ = 1'b1;

        // Reset, park, grant via gap, transaction, park-master grant without gap.
        tbl[0]  = '{1'b0, 4'hF, 1'b1, 1'b1, 4'hF, 1'b0, 2'd0, 1'b1, 1'b0};
        tbl[1]  = '{1'b1, 4'hF, 1'b1, 1'b1, 4'hE, 1'b1, 2'd0, 1'b1, 1'b0};
        tbl[2]  = '{1'b1, 4'hF, 1'b1, 1'b1, 4'hE, 1'b1, 2'd0, 1'b1, 1'b0};
        tbl[3]  = '{1'b1, 4'hD, 1'b1, 1'b1, 4'hF, 1'b0, 2'd0, 1'b1, 1'b0};
        tbl[4]  = '{1'b1, 4'hD, 1'b1, 1'b1, 4'hD, 1'b1, 2'd1, 1'b1, 1'b0};
        tbl[5]  = '{1'b1, 4'hD, 1'b0, 1'b1, 4'hD, 1'b1, 2'd1, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 4'hD, 1'b1, 1'b0, 4'hD, 1'b1, 2'd1, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 4'hF, 1'b1, 1'b1, 4'hD, 1'b1, 2'd1, 1'b1, 1'b0};
        tbl[8]  = '{1'b1, 4'hF, 1'b1, 1'b1, 4'hF, 1'b0, 2'd0, 1'b1, 1'b0};
        tbl[9]  = '{1'b1, 4'hF, 1'b1, 1'b1, 4'hE, 1'b1, 2'd0, 1'b1, 1'b0};
        tbl[10] = '{1'b1, 4'hE, 1'b1, 1'b1, 4'hE, 1'b1, 2'd0, 1'b1, 1'b0};
        tbl[11] = '{1'b1, 4'hF, 1'b1, 1'b1, 4'hF, 1'b0, 2'd0, 1'b1, 1'b0};
        tbl[12] = '{1'b1, 4'hF, 1'b1, 1'b1, 4'hE, 1'b1, 2'd0, 1'b1, 1'b0};

        for (int i = 0; i < 13; i++) begin
            step(tbl[i].rst, tbl[i].req, tbl[i].fr, tbl[i].ir);
            check($sformatf("vec%0d_gnt", i), 32'(GNT_), 32'(tbl[i].gnt));
            check($sformatf("vec%0d_vld", i), 32'(owner_vld), 32'(tbl[i].vld));
            if (tbl[i].vld) check($sformatf("vec%0d_owner", i), 32'(owner), 32'(tbl[i].own));
            check($sformatf("vec%0d_idle", i), 32'(bus_idle), 32'(tbl[i].idle));
            check($sformatf("vec%0d_terr", i), 32'(timeout_err), 32'(tbl[i].terr));
        end

        // Round-robin rotation with all masters requesting.
        step(1'b0, 4'hF, 1'b1, 1'b1);
        step(1'b1, 4'h0, 1'b1, 1'b1);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("rot%0d_grant", k), 32'(GNT_), 32'(gnt_of(k % N)));
            step(1'b1, 4'h0, 1'b0, 1'b0);
            step(1'b1, 4'h0, 1'b1, 1'b0);
            check($sformatf("rot%0d_gap", k), 32'(GNT_), 32'hF);
            step(1'b1, 4'h0, 1'b1, 1'b1);
        end

        // Grant timeout on an idle bus, then rotation to the next requester.
        step(1'b0, 4'hF, 1'b1, 1'b1);
        step(1'b1, 4'hB, 1'b1, 1'b1);
        check("to_grant", 32'(GNT_), 32'hB);
        for (int j = 1; j < TO; j++) begin
            step(1'b1, 4'hB, 1'b1, 1'b1);
            check($sformatf("to_hold%0d", j), 32'({GNT_, timeout_err}), 32'({4'hB, 1'b0}));
        end
        step(1'b1, 4'hB, 1'b1, 1'b1);
        check("to_revoke", 32'({GNT_, timeout_err}), 32'({4'hF, 1'b1}));
        step(1'b1, 4'h3, 1'b1, 1'b1);
        check("to_next", 32'({GNT_, timeout_err}), 32'({4'h7, 1'b0}));

        // Hidden arbitration: master 3 granted while master 1's transaction runs.
        step(1'b0, 4'hF, 1'b1, 1'b1);
        step(1'b1, 4'hD, 1'b1, 1'b1);
        check("hid_grant1", 32'(GNT_), 32'hD);
        step(1'b1, 4'hD, 1'b0, 1'b1);
        check("hid_busy1", 32'(GNT_), 32'hD);
        step(1'b1, 4'h5, 1'b0, 1'b0);
        check("hid_gap", 32'(GNT_), 32'hF);
        step(1'b1, 4'h5, 1'b0, 1'b0);
        check("hid_grant3", 32'(GNT_), 32'h7);
        step(1'b1, 4'h5, 1'b0, 1'b0);
        step(1'b1, 4'h5, 1'b1, 1'b1);
        step(1'b1, 4'h5, 1'b0, 1'b1);
        check("hid_start3", 32'({GNT_, owner}), 32'({4'h7, 2'd3}));
        step(1'b1, 4'hF, 1'b0, 1'b0);
        check("hid_busy3_hold", 32'(GNT_), 32'h7);
        step(1'b1, 4'hF, 1'b1, 1'b1);
        step(1'b1, 4'hF, 1'b1, 1'b1);
        check("hid_release", 32'(GNT_), 32'hF);

        // Reset during a transaction.
        step(1'b1, 4'hD, 1'b1, 1'b1);
        step(1'b1, 4'hD, 1'b0, 1'b1);
        step(1'b0, 4'hD, 1'b0, 1'b1);
        check("rst_busy", 32'({GNT_, owner_vld, owner}), 32'({4'hF, 1'b0, 2'd0}));
        step(1'b1, 4'hF, 1'b1, 1'b1);

        // Randomized traffic with slowly varying request and bus activity levels.
        begin
            logic [3:0] req;
            int dens, frate;
            req = 4'hF; dens = 1; frate = 2;
            for (int c = 0; c < 4000; c++) begin
                logic fr, ir, rst;
                if (c % 64 == 0) begin
                    dens  = $urandom_range(0, 3);
                    frate = $urandom_range(0, 4);
                end
                for (int b = 0; b < N; b++)
                    if ($urandom_range(0, 3) == 0) req[b] = ($urandom_range(0, 5) >= dens * 2);
                fr  = ($urandom_range(0, 15) >= frate);
                ir  = fr ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 1) != 0);
                rst = ($urandom_range(0, 499) != 0);
                step(rst, req, fr, ir);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
